// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the 5-stage pipeline. Sits between Execute and
// Write-Back. Non-memory instructions are registered straight through to
// Write-Back. Loads and stores issue a single-outstanding request/acknowledge
// transaction to the data memory, and Execute is stalled while it is pending.
//
// Parameters
//   TIMEOUT        max cycles dmem_req may stay high without dmem_ack (1..255)
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   ex_*           instruction presented by Execute (held while mem_stall=1)
//   mem_stall      Execute must hold its current instruction
//   dmem_*         data-memory request/acknowledge port
//   wb_*           registered result toward Write-Back (one pulse per retire)
//   fwd_*          forwarding copy of the Write-Back register
//   mem_err        sticky timeout error, cleared only by reset
//   dbg_state      current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshakes
//   Execute -> stage: an instruction transfers on a rising edge where
//   ex_valid=1 and mem_stall=0 (mem_stall is the inverse of ready). While
//   mem_stall=1 Execute keeps ex_* stable and the stage ignores them.
//   Stage -> memory: dmem_req stays high with dmem_addr/dmem_we/dmem_wdata
//   stable until the cycle in which dmem_ack=1; that cycle completes the
//   request. dmem_ack is ignored while dmem_req=0. If no ack arrives within
//   TIMEOUT request cycles the request is withdrawn.
//   Write-Back applies no backpressure.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  // Execute side
  input  logic        ex_valid,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_data,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [3:0]  ex_reg_dest,
  input  logic        ex_reg_wr,
  output logic        mem_stall,
  // Data memory
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  // Write-Back
  output logic        wb_valid,
  output logic        wb_reg_wr,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_reg_dest,
  // Forwarding to Execute
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_dest,
  // Status
  output logic        mem_err,
  output logic        dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter value of the last request cycle allowed before abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // FSM and timeout counter
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Captured memory request
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  dest_q, dest_d;
  logic        reg_wr_q, reg_wr_d;

  // Write-Back register
  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_wr_q, wb_reg_wr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_dest_q, wb_dest_d;

  // One-entry holding slot for a non-memory result accepted in the same
  // cycle a memory access retires: both want the Write-Back register on the
  // same edge, so the later instruction is delayed by one cycle. Once the
  // slot is in use, back-to-back non-memory results flow through it in order
  // until a cycle with nothing to retire lets it drain.
  logic        skid_valid_q, skid_valid_d;
  logic        skid_reg_wr_q, skid_reg_wr_d;
  logic [31:0] skid_data_q, skid_data_d;
  logic [3:0]  skid_dest_q, skid_dest_d;

  // Sticky error
  logic        err_q, err_d;

  // Control terms
  logic        in_wait;
  logic        timeout_fire;
  logic        retire;
  logic        accept;
  logic        is_mem;
  logic        acc_mem;
  logic        acc_alu;

  assign in_wait      = (state_q == WAIT);
  // Ack in the final allowed cycle wins over the timeout.
  assign timeout_fire = in_wait & ~dmem_ack & (cnt_q == CNT_LAST);
  assign retire       = in_wait & (dmem_ack | timeout_fire);
  // Combinational so Execute can advance in the completing cycle and the next
  // instruction is captured on the same edge the current access retires.
  assign mem_stall    = in_wait & ~dmem_ack & ~timeout_fire;
  assign accept       = ex_valid & ~mem_stall;
  assign is_mem       = ex_mem_rd | ex_mem_wr;
  assign acc_mem      = accept & is_mem;
  assign acc_alu      = accept & ~is_mem;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    dest_d        = dest_q;
    reg_wr_d      = reg_wr_q;
    wb_valid_d    = 1'b0;
    wb_reg_wr_d   = 1'b0;
    wb_data_d     = wb_data_q;
    wb_dest_d     = wb_dest_q;
    skid_valid_d  = 1'b0;
    skid_reg_wr_d = skid_reg_wr_q;
    skid_data_d   = skid_data_q;
    skid_dest_d   = skid_dest_q;
    err_d         = err_q | timeout_fire;

    unique case (state_q)
      IDLE: begin
        if (acc_mem) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (retire) begin
          state_d = acc_mem ? WAIT : IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture a new memory access (from IDLE or in the retiring cycle).
    // Store takes priority when both rd and wr are set.
    if (acc_mem) begin
      cnt_d    = 8'd0;
      addr_d   = ex_mem_addr;
      wdata_d  = ex_mem_data;
      we_d     = ex_mem_wr;
      dest_d   = ex_reg_dest;
      reg_wr_d = ex_reg_wr;
    end

    // Write-Back register source, in priority order:
    //   retiring memory access, then the holding slot, then a direct
    //   non-memory result.
    if (retire) begin
      wb_valid_d = 1'b1;
      wb_dest_d  = dest_q;
      if (dmem_ack) begin
        // Stores report their address and never write the register file.
        wb_data_d   = we_q ? addr_q : dmem_rdata;
        wb_reg_wr_d = reg_wr_q & ~we_q;
      end else begin
        // Aborted access: report the faulting address, suppress the write.
        wb_data_d   = addr_q;
        wb_reg_wr_d = 1'b0;
      end
    end else if (skid_valid_q) begin
      wb_valid_d  = 1'b1;
      wb_data_d   = skid_data_q;
      wb_dest_d   = skid_dest_q;
      wb_reg_wr_d = skid_reg_wr_q;
    end else if (acc_alu) begin
      wb_valid_d  = 1'b1;
      wb_data_d   = ex_alu_result;
      wb_dest_d   = ex_reg_dest;
      wb_reg_wr_d = ex_reg_wr;
    end

    if (acc_alu && (retire || skid_valid_q)) begin
      skid_valid_d  = 1'b1;
      skid_data_d   = ex_alu_result;
      skid_dest_d   = ex_reg_dest;
      skid_reg_wr_d = ex_reg_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      we_q          <= 1'b0;
      dest_q        <= 4'd0;
      reg_wr_q      <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_reg_wr_q   <= 1'b0;
      wb_data_q     <= 32'd0;
      wb_dest_q     <= 4'd0;
      skid_valid_q  <= 1'b0;
      skid_reg_wr_q <= 1'b0;
      skid_data_q   <= 32'd0;
      skid_dest_q   <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      dest_q        <= dest_d;
      reg_wr_q      <= reg_wr_d;
      wb_valid_q    <= wb_valid_d;
      wb_reg_wr_q   <= wb_reg_wr_d;
      wb_data_q     <= wb_data_d;
      wb_dest_q     <= wb_dest_d;
      skid_valid_q  <= skid_valid_d;
      skid_reg_wr_q <= skid_reg_wr_d;
      skid_data_q   <= skid_data_d;
      skid_dest_q   <= skid_dest_d;
      err_q         <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // dmem_req comes straight from the state register so an asynchronous reset
  // withdraws the request immediately.
  assign dmem_req    = in_wait;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;

  assign wb_valid    = wb_valid_q;
  assign wb_reg_wr   = wb_reg_wr_q;
  assign wb_data     = wb_data_q;
  assign wb_reg_dest = wb_dest_q;

  assign fwd_valid   = wb_valid_q & wb_reg_wr_q;
  assign fwd_data    = wb_data_q;
  assign fwd_dest    = wb_dest_q;

  assign mem_err     = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage with TIMEOUT=4. The bench plays Execute
// (driver tasks) and the data memory (responder with per-request latency).
// Every accepted instruction pushes its expected Write-Back record, derived
// from the instruction and its chosen memory latency, onto exp_q; a monitor
// pops one record per wb_valid pulse, so results are checked in program
// order independent of cycle timing. Timing corner cases are covered by a
// table of single-instruction vectors and a few hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int TO = 4;
  localparam int W  = 38;   // {err, reg_wr, dest[3:0], data[31:0]}

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_mem_data = '0;
  logic [31:0] ex_alu_result = '0;
  logic        ex_mem_rd = 1'b0;
  logic        ex_mem_wr = 1'b0;
  logic [3:0]  ex_reg_dest = '0;
  logic        ex_reg_wr = 1'b0;
  logic        mem_stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        wb_valid, wb_reg_wr;
  logic [31:0] wb_data;
  logic [3:0]  wb_reg_dest;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_dest;
  logic        mem_err;
  logic        dbg_state;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_mem_addr  (ex_mem_addr),
    .ex_mem_data  (ex_mem_data),
    .ex_alu_result(ex_alu_result),
    .ex_mem_rd    (ex_mem_rd),
    .ex_mem_wr    (ex_mem_wr),
    .ex_reg_dest  (ex_reg_dest),
    .ex_reg_wr    (ex_reg_wr),
    .mem_stall    (mem_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .wb_valid     (wb_valid),
    .wb_reg_wr    (wb_reg_wr),
    .wb_data      (wb_data),
    .wb_reg_dest  (wb_reg_dest),
    .fwd_valid    (fwd_valid),
    .fwd_data     (fwd_data),
    .fwd_dest     (fwd_dest),
    .mem_err      (mem_err),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic         err_model = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    int          lat;
  } req_t;

  req_t rsp_q[$];
  req_t cur;
  bit   active = 0;
  int   rcnt = 0;
  bit   spurious = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Data-memory responder: acks the request in its lat-th cycle, gives up
  // tracking after TO cycles (the stage withdraws the request then).
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    dmem_ack = 1'b0;
    if (!rst_n) begin
      active = 0;
      rcnt   = 0;
    end else if (dmem_req) begin
      if (!active) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: dmem_req=1 with no outstanding access (t=%0t)", $time);
        end else begin
          cur    = rsp_q.pop_front();
          active = 1;
          rcnt   = 0;
        end
      end
      if (active) begin
        rcnt++;
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
        if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
        dmem_ack   = (rcnt == cur.lat);
        dmem_rdata = dmem_ack ? cur.rdata : $urandom();
        if (dmem_ack || rcnt == TO) active = 0;
      end
    end else begin
      dmem_ack   = spurious;
      dmem_rdata = $urandom();
    end
  end

  // ---------------------------------------------------------------------------
  // Write-Back monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: wb_valid=1 data=0x%08h with nothing expected (t=%0t)", wb_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (e[37]) err_model = 1'b1;
          chk("wb_data", wb_data, e[31:0]);
          chk("wb_reg_dest", 32'(wb_reg_dest), 32'(e[35:32]));
          chk("wb_reg_wr", 32'(wb_reg_wr), 32'(e[36]));
          chk("fwd_valid", 32'(fwd_valid), 32'(e[36]));
          chk("fwd_data", fwd_data, e[31:0]);
          chk("fwd_dest", 32'(fwd_dest), 32'(e[35:32]));
        end
      end else begin
        chk("fwd_valid_idle", 32'(fwd_valid), 32'd0);
      end
      chk("mem_err", 32'(mem_err), 32'(err_model));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    ex_valid = 1'b0;
    spurious = 0;
    exp_q.delete();
    rsp_q.delete();
    err_model = 1'b0;
    #1;
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_reg_dest", 32'(wb_reg_dest), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_fwd_dest", 32'(fwd_dest), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Present one instruction, hold it until accepted, record its expected
  // retirement. Entered and left 1 ns after a rising edge.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] alu,
                       input logic [3:0] dest, input logic reg_wr, input int lat,
                       input logic [31:0] rdata, output int stalls);
    logic [W-1:0] e;
    req_t r;
    bit ok;
    ex_valid      = 1'b1;
    ex_mem_rd     = rd;
    ex_mem_wr     = wr;
    ex_mem_addr   = addr;
    ex_mem_data   = data;
    ex_alu_result = alu;
    ex_reg_dest   = dest;
    ex_reg_wr     = reg_wr;
    stalls = 0;
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!mem_stall) begin
        ok = 1;
        break;
      end
      stalls++;
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instruction not accepted after %0d cycles", stalls);
      ex_valid = 1'b0;
      return;
    end
    if (rd | wr) begin
      r.addr  = addr;
      r.wdata = data;
      r.rdata = rdata;
      r.we    = wr;
      r.lat   = lat;
      rsp_q.push_back(r);
      if (lat <= TO) e = wr ? {1'b0, 1'b0, dest, addr} : {1'b0, reg_wr, dest, rdata};
      else           e = {1'b1, 1'b0, dest, addr};
    end else begin
      e = {1'b0, reg_wr, dest, alu};
    end
    exp_q.push_back(e);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (8) tick();
    chk({name, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_req_empty"}, 32'(rsp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one instruction from reset, expected first wb cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] alu;
    logic [3:0]  dest;
    logic        reg_wr;
    int          lat;
    logic [31:0] rdata;
    int          exp_cyc;
    logic [31:0] exp_data;
    logic        exp_reg_wr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  initial begin
    int st;
    int n;
    int found;

    vecs[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_1234, 4'd5,  1'b1, 0,  32'h0,         1, 32'h0000_1234, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'd15, 1'b0, 0,  32'h0,         1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'h0,        4'd3,  1'b1, 3,  32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h80, 32'h0, 32'h0,        4'd7,  1'b1, 1,  32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0, 4'd2, 1'b1, 1,  32'h0,         2, 32'h0000_0010, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h20, 32'h0000_5A5A, 32'h0, 4'd9, 1'b1, 2,  32'h1111_1111, 3, 32'h0000_0020, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h44, 32'h0, 32'h0,        4'd1,  1'b1, 4,  32'h1234_5678, 5, 32'h1234_5678, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 32'h48, 32'h0, 32'h0,        4'd4,  1'b1, 99, 32'h0,         5, 32'h0000_0048, 1'b0, 1'b1};

    for (int i = 0; i < NV; i++) begin
      apply_reset();
      issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].alu,
            vecs[i].dest, vecs[i].reg_wr, vecs[i].lat, vecs[i].rdata, st);
      found = 0;
      for (int c = 1; c <= 20; c++) begin
        #1;
        if (wb_valid) begin
          found = c;
          break;
        end
        tick();
      end
      chk($sformatf("vec%0d_latency", i), 32'(found), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_wb_reg_wr", i), 32'(wb_reg_wr), 32'(vecs[i].exp_reg_wr));
      chk($sformatf("vec%0d_wb_reg_dest", i), 32'(wb_reg_dest), 32'(vecs[i].dest));
      chk($sformatf("vec%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].exp_reg_wr));
      chk($sformatf("vec%0d_fwd_dest", i), 32'(fwd_dest), 32'(vecs[i].dest));
      chk($sformatf("vec%0d_mem_err", i), 32'(mem_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_mem_stall", i), 32'(mem_stall), 32'd0);
      tick();
      drain($sformatf("vec%0d", i));
    end

    // Load, ack after 3 request cycles: stall 2 cycles, released in ack cycle.
    apply_reset();
    issue(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 4'd6, 1'b1, 3, 32'hDEAD_BEEF, st);
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("ld3_req%0d", c), 32'(dmem_req), 32'd1);
      chk($sformatf("ld3_stall%0d", c), 32'(mem_stall), 32'(c < 3));
      tick();
    end
    #1;
    chk("ld3_wb_valid", 32'(wb_valid), 32'd1);
    chk("ld3_wb_data", wb_data, 32'hDEAD_BEEF);
    tick();
    drain("ld3");

    // Store acked in its first request cycle, load presented in that cycle.
    apply_reset();
    issue(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'h0, 4'd2, 1'b1, 1, 32'h0, st);
    issue(1'b1, 1'b0, 32'h30, 32'h0, 32'h0, 4'd6, 1'b1, 2, 32'hCAFE_0001, st);
    chk("b2b_load_stalls", 32'(st), 32'd0);
    #1;
    chk("b2b_req", 32'(dmem_req), 32'd1);
    chk("b2b_addr", dmem_addr, 32'h30);
    chk("b2b_we", 32'(dmem_we), 32'd0);
    chk("b2b_store_wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b_store_wb_reg_wr", 32'(wb_reg_wr), 32'd0);
    tick();
    drain("b2b");

    // Timeout: request high exactly TO cycles, then sticky error.
    apply_reset();
    issue(1'b1, 1'b0, 32'h48, 32'h0, 32'h0, 4'd4, 1'b1, 99, 32'h0, st);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (dmem_req) begin
        n++;
        chk($sformatf("to_stall%0d", n), 32'(mem_stall), 32'(n < TO));
      end
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'(TO));
    chk("to_mem_err", 32'(mem_err), 32'd1);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0777, 4'd11, 1'b1, 0, 32'h0, st);
    drain("to");
    chk("to_err_sticky", 32'(mem_err), 32'd1);

    // Spurious ack while idle, ex_* changes during a stall.
    apply_reset();
    spurious = 1;
    repeat (3) tick();
    spurious = 0;
    #1;
    chk("spur_req", 32'(dmem_req), 32'd0);
    chk("spur_stall", 32'(mem_stall), 32'd0);
    chk("spur_wb_valid", 32'(wb_valid), 32'd0);
    tick();
    issue(1'b1, 1'b0, 32'h60, 32'h0, 32'h0, 4'd8, 1'b1, 3, 32'h600D_600D, st);
    ex_valid      = 1'b1;
    ex_mem_wr     = 1'b1;
    ex_mem_addr   = 32'hBAD0_0000;
    ex_alu_result = 32'hBAD0_0001;
    tick();
    ex_mem_addr   = 32'hBAD0_0002;
    ex_mem_rd     = 1'b0;
    ex_mem_wr     = 1'b0;
    tick();
    ex_valid = 1'b0;
    drain("held");
    chk("held_req_idle", 32'(dmem_req), 32'd0);

    // Reset in the middle of an access, then a normal ALU instruction.
    apply_reset();
    issue(1'b1, 1'b0, 32'h70, 32'h0, 32'h0, 4'd12, 1'b1, 3, 32'h7777_0000, st);
    #1;
    apply_reset();
    issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0077, 4'd10, 1'b1, 0, 32'h0, st);
    #1;
    chk("rstmid_wb_valid", 32'(wb_valid), 32'd1);
    chk("rstmid_wb_data", wb_data, 32'h0000_0077);
    tick();
    drain("rstmid");

    // Randomized mix against the order-based model.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      int kind;
      int lat;
      kind = $urandom_range(0, 3);
      lat  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(1, TO);
      issue(kind == 1 || kind == 3, kind == 2 || kind == 3, $urandom(), $urandom(),
            $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat, $urandom(), st);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, sitting directly downstream of the Execute stage and upstream of Write-Back. It takes the address, store data, write strobe and destination register from Execute and issues a single-outstanding request/acknowledge transaction to the data memory. Load data or pass-through results are registered toward Write-Back and forwarded back to Execute. While a memory access is pending, the stage stalls Execute.

## Interface
- TIMEOUT, 15: maximum number of cycles `dmem_req` stays high without `dmem_ack` before the access is aborted; legal range 1..255.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  an instruction is presented by Execute this cycle.
- ex_mem_addr  in  32  word address, used when `ex_mem_rd` or `ex_mem_wr` is set.
- ex_mem_data  in  32  store data.
- ex_alu_result  in  32  result passed to Write-Back for non-load instructions.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store; takes priority if both `ex_mem_rd` and `ex_mem_wr` are set.
- ex_reg_dest  in  4  destination register.
- ex_reg_wr  in  1  instruction writes `ex_reg_dest`.
- mem_stall  out  1  Execute must hold its current instruction.
- dmem_req, dmem_we  out  1 each  memory request and write enable.
- dmem_addr, dmem_wdata  out  32 each  request address and write data.
- dmem_rdata  in  32  read data, valid when `dmem_ack` is high.
- dmem_ack  in  1  completes the current request.
- wb_valid, wb_reg_wr  out  1 each  Write-Back register valid; register-write enable.
- wb_data  out  32  load data or ALU result.
- wb_reg_dest  out  4  destination register.
- fwd_valid  out  1  forwarding valid, equal to `wb_valid & wb_reg_wr`.
- fwd_data, fwd_dest  out  32/4  equal to `wb_data` and `wb_reg_dest`.
- mem_err  out  1  sticky timeout error.

## Operation
- **States:** IDLE and WAIT.
- **IDLE, `ex_valid` with `ex_mem_rd` or `ex_mem_wr` set:**
  - Capture addr, data, we (= `ex_mem_wr`), dest and reg_wr.
  - Go to WAIT and clear the timeout counter.
  - `wb_valid` is 0 next cycle.
- **IDLE, `ex_valid` with neither rd nor wr:**
  - Next cycle: `wb_valid`=1, `wb_data`=`ex_alu_result`, dest and reg_wr copied.
- **IDLE, `ex_valid`=0:** `wb_valid`=0 next cycle.
- **WAIT:**
  - `dmem_req`=1; addr, we and wdata are held stable from the captured values until the ack cycle.
  - **`dmem_ack`=1:** go to IDLE. Next cycle `wb_valid`=1.
    - Load: `wb_data`=`dmem_rdata`.
    - Store: `wb_data`=captured addr and `wb_reg_wr` is forced to 0.
  - **No ack:** counter increments. If the counter equals TIMEOUT-1 and ack is low, the access is aborted:
    - Go to IDLE and set `mem_err`=1.
    - Next cycle `wb_valid`=1 with `wb_reg_wr`=0.
  - Ack in the final allowed cycle completes normally; ack wins over timeout.
- **`mem_stall`** = (state==WAIT) & ~`dmem_ack` & ~timeout_fire. It is combinational, so Execute advances during the completing cycle, and the stage accepts the new instruction on that same edge.
  - In the completing cycle, a new instruction presented by Execute is captured per the IDLE rules. This gives back-to-back memory operations with no bubble beyond the access itself.
- `dmem_ack` while `dmem_req`=0 is ignored.
- `ex_*` inputs while `mem_stall`=1 are ignored; Execute holds them.
- `mem_err` stays set until reset. Operation continues normally after it is set.
- Counter width is 8 bits; it never wraps because TIMEOUT ≤ 255.

## Timing
- **Reset values:** all outputs 0 (`mem_stall`, `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, all wb/fwd outputs, `mem_err`). State = IDLE, counter = 0.
- **Reset mid-access:** `dmem_req` drops asynchronously. The access is abandoned, with no WB result and no error.
- **Non-memory latency:** 1 cycle (accept at edge N, `wb_valid` during cycle N+1).
- **Memory latency:** accept at edge N; `dmem_req` high from cycle N+1. Ack in cycle N+k gives `wb_valid` in cycle N+k+1.
  - Minimum is 2 cycles (k=1).
- **Timeout:** `dmem_req` high for exactly TIMEOUT cycles. Abort occurs at the edge ending the last of them, and `mem_err` is high from the following cycle.
- `wb_valid` pulses one cycle per retired instruction. Write-Back applies no backpressure.
- Forwarding outputs are combinational from WB registers, with no extra latency.

## Test plan
- **Reset then ALU pass-through:** ex_valid=1, rd=wr=0, alu=0x1234, dest=5, reg_wr=1.
  - Next cycle: `wb_valid`=1, `wb_data`=0x1234, `fwd_valid`=1, `fwd_dest`=5, `mem_stall`=0.
- **Load with ack after 3 request cycles,** addr=0x40, rdata=0xDEADBEEF:
  - `mem_stall`=1 for 2 cycles, 0 in the ack cycle.
  - `dmem_addr` stable at 0x40, `dmem_we`=0.
  - Next cycle: `wb_data`=0xDEADBEEF.
- **Store addr=0x10 data=0xA5A5A5A5, ack in first request cycle;** a second load is presented in the ack cycle:
  - Store retires with `wb_reg_wr`=0.
  - Load request starts on the very next cycle.
  - Both rd and wr set produces a write.
- **TIMEOUT=4, no ack:**
  - `dmem_req` high exactly 4 cycles, then 0.
  - `mem_err`=1 sticky, `wb_valid`=1 with `wb_reg_wr`=0.
  - Ack arriving in the 4th cycle instead gives a normal completion with `mem_err`=0.
- **Spurious and held inputs:** `dmem_ack` pulse while idle causes no effect. `ex_*` changes during stall are ignored.
- **rst_n low mid-WAIT:** all outputs 0 immediately. After release, an ALU instruction retires normally.
